// File: rtl/icache.sv
// icache: direct-mapped instruction cache; a miss refills the whole line one word at a time.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt performance counters.
module icache #(
  parameter int LINE_NUM       = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] IC_addr,
  input  logic        IC_addr_sgn,
  input  logic        rollback,
  output logic        IC_ins_sgn,
  output logic [31:0] IC_ins,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int W     = $clog2(WORDS_PER_LINE);
  localparam int L     = $clog2(LINE_NUM);
  localparam int KB    = (W > 0) ? W : 1;
  localparam int DEPTH = LINE_NUM * WORDS_PER_LINE;
  localparam int DB    = $clog2(DEPTH);
  localparam int TW    = 32 - W - L - 2;
  localparam logic [KB-1:0] LAST_K = KB'(WORDS_PER_LINE - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t          state_q, state_d;
  logic [KB-1:0]   k_q, k_d;
  logic            insSgn_q, insSgn_d;
  logic [31:0]     ins_q, ins_d;
  logic            memReq_q, memReq_d;
  logic [31:0]     memAddr_q, memAddr_d;
  logic [LINE_NUM-1:0] valid_q, valid_d;
  logic            dataWe, tagWe;

  logic [TW-1:0]   tagMem [LINE_NUM];
  logic [31:0]     dataMem [DEPTH];

  logic [L-1:0]    lookupIdx, refIdx;
  logic [TW-1:0]   lookupTag, refTag;
  logic [DB-1:0]   lookupWord, refWord;
  logic            lookupEn, lookupHit;
  logic            unused_ok;

  // {index, offset} is contiguous in the address, so it directly addresses the flat data array.
  assign lookupIdx  = IC_addr[W+L+1:W+2];
  assign lookupTag  = IC_addr[31:W+L+2];
  assign lookupWord = IC_addr[DB+1:2];
  assign refIdx     = memAddr_q[W+L+1:W+2];
  assign refTag     = memAddr_q[31:W+L+2];
  assign refWord    = memAddr_q[DB+1:2];
  assign unused_ok  = ^IC_addr[1:0];

  assign lookupEn  = IC_addr_sgn && !rollback && !insSgn_q;
  assign lookupHit = valid_q[lookupIdx] && (tagMem[lookupIdx] == lookupTag);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      insSgn_q  <= 1'b0;
      ins_q     <= '0;
      memReq_q  <= 1'b0;
      memAddr_q <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      insSgn_q  <= insSgn_d;
      ins_q     <= ins_d;
      memReq_q  <= memReq_d;
      memAddr_q <= memAddr_d;
      valid_q   <= valid_d;
    end
  end

  // Rollback only gates new lookups; an in-flight refill always runs to completion.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    insSgn_d  = insSgn_q;
    ins_d     = ins_q;
    memReq_d  = memReq_q;
    memAddr_d = memAddr_q;
    valid_d   = valid_q;
    dataWe    = 1'b0;
    tagWe     = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          insSgn_d = 1'b0;
          if (lookupEn) begin
            if (lookupHit) begin
              insSgn_d = 1'b1;
              ins_d    = dataMem[lookupWord];
            end else begin
              state_d   = REFILL;
              k_d       = '0;
              memReq_d  = 1'b1;
              memAddr_d = {IC_addr[31:W+2], {(W+2){1'b0}}};
              valid_d[lookupIdx] = 1'b0;
            end
          end
        end
        REFILL: begin
          if (mem_done) begin
            dataWe   = 1'b1;
            memReq_d = 1'b0;
            if (k_q == LAST_K) begin
              tagWe           = 1'b1;
              valid_d[refIdx] = 1'b1;
              state_d         = IDLE;
              k_d             = '0;
            end else begin
              k_d       = k_q + 1'b1;
              memAddr_d = memAddr_q + 32'd4;
            end
          end else if (!memReq_q) begin
            memReq_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && dataWe) dataMem[refWord] <= mem_data;
    if (rst && tagWe) tagMem[refIdx] <= refTag;
  end

  assign IC_ins_sgn = insSgn_q;
  assign IC_ins     = ins_q;
  assign mem_req    = memReq_q;
  assign mem_addr   = memAddr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hitCnt_q, missCnt_q;
  logic        hitEvt, missEvt;

  assign hitEvt  = rdy && (state_q == IDLE) && lookupEn && lookupHit;
  assign missEvt = rdy && (state_q == IDLE) && lookupEn && !lookupHit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hitCnt_q  <= '0;
      missCnt_q <= '0;
    end else begin
      if (hitEvt) hitCnt_q <= hitCnt_q + 32'd1;
      if (missEvt) missCnt_q <= missCnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hitCnt_q;
  assign miss_cnt = missCnt_q;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache that answers instruction fetch requests over the `IC_addr`/`IC_addr_sgn` → `IC_ins_sgn`/`IC_ins` interface. On a miss it refills a whole line from the memory controller, one word per request/done handshake. It sits between the fetch unit and the memory controller.

## Interface
- `LINE_NUM`, default 32: number of lines; power of two, ≥2.
- `WORDS_PER_LINE`, default 4: 32-bit words per line; power of two, ≥1.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: reset, synchronous, active-low. Asserted when `rst==0` at a rising edge.
- `rdy  in  1`: global ready. When 0, all state is frozen.
- `IC_addr  in  32`: fetch address. Bits [1:0] are ignored.
- `IC_addr_sgn  in  1`: fetch request valid (level).
- `rollback  in  1`: fetch redirect. Kills any response for the current address.
- `IC_ins_sgn  out  1`: one-cycle pulse; `IC_ins` is valid for the sampled address.
- `IC_ins  out  32`: instruction word.
- `mem_req  out  1`: word read request to the memory controller.
- `mem_addr  out  32`: word-aligned read address; held while `mem_req` is high.
- `mem_done  in  1`: one-cycle pulse; `mem_data` is valid.
- `mem_data  in  32`: returned word.
- `hit_cnt  out  32`, `miss_cnt  out  32`: present only with `ICACHE_STATS_EN`.

## Operation
- Address split, with W=log2(WORDS_PER_LINE) and L=log2(LINE_NUM):
  - word offset = addr[W+1:2]
  - index = addr[W+L+1:W+2]
  - tag = addr[31:W+L+2]
- Storage: per-line valid bit, tag, and `WORDS_PER_LINE` data words.
- State machine has two states, IDLE and REFILL.
- IDLE, at an edge with `rdy=1`:
  - The block performs a lookup only when `IC_addr_sgn=1`, `rollback=0` and `IC_ins_sgn` is currently 0.
  - Hit: `IC_ins_sgn<=1` and `IC_ins<=` the addressed word.
  - Miss: go to REFILL with counter k=0; `mem_req<=1`; `mem_addr<={tag,index,k,2'b00}`; line valid bit cleared.
  - `IC_ins_sgn` is never high for two consecutive cycles. The cycle after a pulse is a forced bubble, which lets fetch advance its PC.
- REFILL:
  - On `mem_done`: write `mem_data` into word k and set `mem_req<=0`.
  - If k is not the last word: increment k; re-assert `mem_req` one cycle later with the next address.
  - After the last word: write the tag, set valid, return to IDLE.
  - No response is issued from REFILL. The following IDLE lookup hits.
- Rollback:
  - In IDLE, rollback suppresses the lookup at that edge.
  - In REFILL, the refill always completes and the line is installed. A `mem_done` coinciding with `rollback` is still written.
  - The next lookup uses the new `IC_addr`.
- `rdy=0`: the state machine, counters and outputs hold. The memory controller never pulses `mem_done` while `rdy=0`.

## Timing
- Reset values: `IC_ins_sgn=0`, `IC_ins=0`, `mem_req=0`, `mem_addr=0`, state IDLE, k=0, all valid bits 0, counters 0.
- Hit latency: request sampled at edge n, `IC_ins_sgn` high during cycle n+1.
- Maximum throughput is 1 instruction per 2 cycles.
- Miss latency: 1 cycle to issue, plus the sum of the memory latencies, plus 1 idle cycle between words, plus 1 lookup cycle.
- `mem_req` drops for at least 1 cycle after each `mem_done`.
- Reset mid-refill: the refill is abandoned and the line stays invalid. `mem_req=0` from the next cycle.
- Counter k wraps to 0 only on return to IDLE.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Ports `hit_cnt`/`miss_cnt` exist.
  - `hit_cnt` increments on each `IC_ins_sgn` pulse; `miss_cnt` increments on each IDLE→REFILL transition.
  - Both are reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; functional behaviour is identical.

## Test plan
- Reset: hold `rst=0` for 2 cycles with `IC_addr_sgn=1` → all outputs 0, no `mem_req`. Release → request 0x0 misses; `mem_req=1`, `mem_addr=0x0`.
- Cold miss with defaults: request 0x8, memory returns `mem_done` 3 cycles after each `mem_req`, data = addr+0x100 → `mem_addr` sequence 0x0, 0x4, 0x8, 0xC. Then exactly one `IC_ins_sgn` pulse with `IC_ins=0x108`.
- Back-to-back hits: hold `IC_addr=0x4`, `IC_addr_sgn=1` after the refill → `IC_ins_sgn` pattern 1,0,1,0, `IC_ins=0x104`; no `mem_req`.
- Conflict: fetch 0x0, then 0x200 (same index 0) → second miss refills 0x200–0x20C. A subsequent fetch of 0x0 misses again.
- Rollback mid-refill: pulse `rollback` while word 2 is outstanding and switch `IC_addr` to 0x40 → words 2 and 3 of the old line are still fetched, no pulse for the old address, then a refill at 0x40 and a pulse.
- `rdy=0` for 5 cycles during REFILL and during a pending hit → `mem_addr`/`mem_req`/`IC_ins_sgn` hold. With `ICACHE_STATS_EN`, after the cold-miss and hit scenarios → `miss_cnt=1`, `hit_cnt=3`.
